mem_arbiter: RTL

- Shares one single-port synchronous memory between the processor's instruction-fetch port and its load/store data port.
- Arbitrates per access using round-robin and issues the access to the memory.
- Routes read data back to the owning requester.
- Counts contention cycles for performance debug.
- Sits between the processor core and the unified program/data memory.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_rr_pick2.sv | 35 +++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;

    // IDLE arbitrates and issues; READ_WAIT covers the cycle a read is in flight.
    typedef enum logic {
        IDLE      = 1'b0,
        READ_WAIT = 1'b1
    } state_e;

    // Requester identity, used for grant history and response routing.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins; on a tie, the one
// that did not win last time wins. Purely combinational.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic       i_valid_if,
    input  logic       i_valid_d,
    input  logic       i_last_grant,   // owner_e encoding
    output logic [1:0] o_grant,        // [0] fetch, [1] data
    output logic       o_winner        // owner_e encoding
);

    // Select the winner from the two valids and the previous grant.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_grant  = 2'b00;
        o_winner = OWN_IF;
        if (i_valid_if && i_valid_d) begin
            if (i_last_grant == OWN_D) begin
                o_grant  = 2'b01;
                o_winner = OWN_IF;
            end else begin
                o_grant  = 2'b10;
                o_winner = OWN_D;
            end
        end else if (i_valid_if) begin
            o_grant  = 2'b01;
            o_winner = OWN_IF;
        end else if (i_valid_d) begin
            o_grant  = 2'b10;
            o_winner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between the fetch port and the
// load/store port. One access per IDLE cycle, round-robin on contention,
// registered one-cycle responses routed to the owner, and a saturating
// count of contended IDLE cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_resp_data,

    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [CNT_W-1:0]  conflict_count
);

    state_e            r_state;
    owner_e            r_last_grant;
    owner_e            r_owner;
    logic              r_if_resp_valid;
    logic [DATA_W-1:0] r_if_resp_data;
    logic              r_d_resp_valid;
    logic [DATA_W-1:0] r_d_resp_rdata;
    logic [CNT_W-1:0]  r_conflict_count;

    logic              w_idle;
    logic [1:0]        w_grant;
    logic              w_winner;
    logic              w_accept;
    logic              w_win_d;
    logic              w_mem_we;
    logic              w_conflict;

    // Grants are only offered in IDLE and never while reset is asserted.
    assign w_idle = (r_state == IDLE) && !reset;

    rr_pick2 u_pick (
        .i_valid_if   (if_req_valid && w_idle),
        .i_valid_d    (d_req_valid && w_idle),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_winner     (w_winner)
    );

    assign w_accept   = |w_grant;
    assign w_win_d    = w_grant[1];
    assign w_mem_we   = w_win_d && d_req_we;
    assign w_conflict = (r_state == IDLE) && if_req_valid && d_req_valid;

    assign if_req_ready = w_grant[0];
    assign d_req_ready  = w_grant[1];

    // The memory access is issued combinationally in the accept cycle.
    assign mem_en    = w_accept;
    assign mem_we    = w_mem_we;
    assign mem_addr  = w_win_d ? d_req_addr : if_req_addr;
    assign mem_wdata = w_mem_we ? d_req_wdata : '0;

    assign if_resp_valid  = r_if_resp_valid;
    assign if_resp_data   = r_if_resp_data;
    assign d_resp_valid   = r_d_resp_valid;
    assign d_resp_rdata   = r_d_resp_rdata;
    assign conflict_count = r_conflict_count;

    // Arbiter FSM: tracks the in-flight read and produces the registered responses.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state         <= IDLE;
            r_last_grant    <= OWN_D;
            r_owner         <= OWN_IF;
            r_if_resp_valid <= 1'b0;
            r_if_resp_data  <= '0;
            r_d_resp_valid  <= 1'b0;
            r_d_resp_rdata  <= '0;
        end else begin
            r_if_resp_valid <= 1'b0;
            r_d_resp_valid  <= 1'b0;
            if (w_accept) begin
                r_last_grant <= owner_e'(w_winner);
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_mem_we) begin
                            r_d_resp_valid <= 1'b1;
                            r_d_resp_rdata <= '0;
                        end else begin
                            r_state <= READ_WAIT;
                            r_owner <= owner_e'(w_winner);
                        end
                    end
                end
                READ_WAIT: begin
                    r_state <= IDLE;
                    if (r_owner == OWN_IF) begin
                        r_if_resp_valid <= 1'b1;
                        r_if_resp_data  <= mem_rdata;
                    end else begin
                        r_d_resp_valid <= 1'b1;
                        r_d_resp_rdata <= mem_rdata;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Saturating count of IDLE cycles in which both requesters were waiting.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_conflict_count <= '0;
        end else if (w_conflict && !(&r_conflict_count)) begin
            r_conflict_count <= r_conflict_count + CNT_W'(1);
        end
    end

endmodule
